// File: rtl/mult_share_pkg.sv
// Shared types and widths for the shared-multiplier front end.
package mult_share_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mult_share_arbiter_rr.sv
// Combinational round-robin arbiter: searches from last_grant+1 upward and
// wraps, so the most recent winner has the lowest priority.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id
);

    logic found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (int'(last_grant) + k) % N_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one external 4x4 multiplier between N_REQ requesters: IDLE grants
// and latches operands, MUL samples the product, RESP holds it until consumed.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [4*N_REQ-1:0]    req_x,
    input  logic [4*N_REQ-1:0]    req_y,
    output logic [N_REQ-1:0]      req_ready,
    output logic [OP_W-1:0]       mul_x,
    output logic [OP_W-1:0]       mul_y,
    input  logic [PROD_W-1:0]     mul_z,
    output logic                  rsp_valid,
    output logic [PROD_W-1:0]     rsp_data,
    output logic [ID_W-1:0]       rsp_id,
    input  logic                  rsp_ready,
    output logic                  busy
);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [OP_W-1:0]     mul_x_q, mul_x_d;
    logic [OP_W-1:0]     mul_y_q, mul_y_d;
    logic [PROD_W-1:0]   rsp_data_q, rsp_data_d;
    logic [N_REQ-1:0]    grant;
    logic [ID_W-1:0]     grant_id;
    logic                accept;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    // Grant is only offered in IDLE, and never while reset is asserted.
    assign accept    = (state_q == IDLE) && (|req_valid);
    assign req_ready = ((state_q == IDLE) && !rst) ? grant : '0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        mul_x_d      = mul_x_q;
        mul_y_d      = mul_y_q;
        rsp_data_d   = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mul_x_d      = req_x[int'(grant_id)*OP_W +: OP_W];
                    mul_y_d      = req_y[int'(grant_id)*OP_W +: OP_W];
                    rsp_id_d     = grant_id;
                    last_grant_d = grant_id;
                    state_d      = MUL;
                end
            end
            MUL: begin
                rsp_data_d = mul_z;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(N_REQ - 1);
            rsp_id_q     <= '0;
            mul_x_q      <= '0;
            mul_y_q      <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            mul_x_q      <= mul_x_d;
            mul_y_q      <= mul_y_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

endmodule
